// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier datapath slice.
//   PROD_W / GUARD / ACC_W / CNT_W : default widths of product, accumulator
//                                    guard bits, accumulator and beat counter
//   state_e                         : product_accumulator group-control states
package mult_pkg;

  localparam int unsigned PROD_W = 64;
  localparam int unsigned GUARD  = 8;
  localparam int unsigned ACC_W  = PROD_W + GUARD;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/product_accumulator.sv
// Registered accumulation stage behind the Booth/Wallace multiplier.
// Products are captured in a pipeline register (S1), then summed into a
// guard-extended accumulator (S2) until a beat flagged "last" arrives.
// The group result is then held until the consumer accepts it.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : product beat handshake
//   in_prod, in_last    : signed product, final-beat-of-group flag
//   acc_clear           : synchronous abort of the current group (ignored in HOLD)
//   out_valid/out_ready : group result handshake
//   out_acc             : signed group sum (wraps modulo 2^ACC_W)
//   out_count           : beats in group, saturating
//   out_overflow        : sticky signed overflow seen during the group
module product_accumulator #(
  parameter int unsigned PROD_W = mult_pkg::PROD_W,
  parameter int unsigned GUARD  = mult_pkg::GUARD,
  parameter int unsigned CNT_W  = mult_pkg::CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PROD_W-1:0]         in_prod,
  input  logic                      in_last,
  input  logic                      acc_clear,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PROD_W+GUARD-1:0]   out_acc,
  output logic [CNT_W-1:0]          out_count,
  output logic                      out_overflow
);

  import mult_pkg::*;

  localparam int unsigned ACC_W = PROD_W + GUARD;

  state_e              state_q, state_d;
  logic                s1_valid_q, s1_valid_d;
  logic [PROD_W-1:0]   s1_prod_q, s1_prod_d;
  logic                s1_last_q, s1_last_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;

  logic                accept;
  logic [ACC_W-1:0]    ext;
  logic [ACC_W-1:0]    sum;

  always_comb begin
    // Gated by rst_n so the block never advertises readiness while held in reset.
    // A last beat sitting in S1 blocks intake so the next group cannot mix in.
    in_ready = rst_n && (state_q != HOLD) && !(s1_valid_q && s1_last_q) && !acc_clear;
    accept   = in_valid && in_ready;

    s1_valid_d = accept;
    s1_prod_d  = s1_prod_q;
    s1_last_d  = s1_last_q;
    if (accept) begin
      s1_prod_d = in_prod;
      s1_last_d = in_last;
    end

    ext = {{GUARD{s1_prod_q[PROD_W-1]}}, s1_prod_q};
    sum = acc_q + ext;

    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (acc_clear) begin
          s1_valid_d = 1'b0;
          acc_d      = '0;
          count_d    = '0;
          ovf_d      = 1'b0;
          state_d    = IDLE;
        end else if (s1_valid_q) begin
          acc_d   = sum;
          count_d = (count_q == '1) ? count_q : count_q + 1'b1;
          // Signed overflow: operands share a sign but the result does not.
          ovf_d   = ovf_q | ((acc_q[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]));
          state_d = s1_last_q ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid    = (state_q == HOLD);
    out_acc      = acc_q;
    out_count    = count_q;
    out_overflow = ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_last_q  <= 1'b0;
      acc_q      <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d;
      s1_prod_q  <= s1_prod_d;
      s1_last_q  <= s1_last_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: hand-computed group results,
// handshake timing, saturation/overflow, backpressure, clear and reset.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_prod;
  logic        in_last;
  logic        acc_clear;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] out_acc;
  logic [7:0]  out_count;
  logic        out_overflow;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  product_accumulator #(.PROD_W(64), .GUARD(8), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_prod      (in_prod),
    .in_last      (in_last),
    .acc_clear    (acc_clear),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_acc      (out_acc),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one beat from a negedge; return at the negedge after the accepting edge.
  task automatic push(input logic [63:0] p, input logic l);
    int unsigned waited = 0;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    #1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) check("push_ready_timeout", {71'd0, in_ready}, 72'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_prod = '0; in_last = 1'b0;
    acc_clear = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  {71'd0, in_ready},     72'd0);
    check("rst_out_valid", {71'd0, out_valid},    72'd0);
    check("rst_out_acc",   out_acc,               72'd0);
    check("rst_out_count", {64'd0, out_count},    72'd0);
    check("rst_out_ovf",   {71'd0, out_overflow}, 72'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", {71'd0, in_ready}, 72'd1);

    // Group 6, -4, 10 -> 12
    push(64'd6, 1'b0);
    push(64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    push(64'd10, 1'b1);
    check("g1_valid_early", {71'd0, out_valid}, 72'd0);
    check("g1_ready_stall", {71'd0, in_ready},  72'd0);
    @(negedge clk);
    check("g1_valid", {71'd0, out_valid},    72'd1);
    check("g1_acc",   out_acc,               72'd12);
    check("g1_count", {64'd0, out_count},    72'd3);
    check("g1_ovf",   {71'd0, out_overflow}, 72'd0);
    @(negedge clk);
    check("g1_done_valid", {71'd0, out_valid}, 72'd0);
    check("g1_done_acc",   out_acc,            72'd0);

    // Single most-negative beat
    push(64'h8000_0000_0000_0000, 1'b1);
    @(negedge clk);
    check("single_valid", {71'd0, out_valid}, 72'd1);
    check("single_acc",   out_acc,            72'hFF_8000_0000_0000_0000);
    check("single_count", {64'd0, out_count}, 72'd1);
    @(negedge clk);

    // 256 x -2^63 reaches -2^71 exactly; one more wraps
    for (int i = 0; i < 256; i++) push(64'h8000_0000_0000_0000, 1'b0);
    @(negedge clk);
    check("sat_acc256",   out_acc,               72'h80_0000_0000_0000_0000);
    check("sat_count256", {64'd0, out_count},    72'd255);
    check("sat_ovf256",   {71'd0, out_overflow}, 72'd0);
    push(64'h8000_0000_0000_0000, 1'b1);
    @(negedge clk);
    check("sat_valid", {71'd0, out_valid},    72'd1);
    check("sat_acc",   out_acc,               72'h7F_8000_0000_0000_0000);
    check("sat_count", {64'd0, out_count},    72'd255);
    check("sat_ovf",   {71'd0, out_overflow}, 72'd1);
    @(negedge clk);
    check("sat_done_ovf", {71'd0, out_overflow}, 72'd0);

    // Backpressure in HOLD
    out_ready = 1'b0;
    push(64'd5, 1'b0);
    push(64'd9, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; in_prod = 64'd100; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready",  {71'd0, in_ready},  72'd0);
      check("bp_out_valid", {71'd0, out_valid}, 72'd1);
      check("bp_out_acc",   out_acc,            72'd14);
      check("bp_out_count", {64'd0, out_count}, 72'd2);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", {71'd0, out_valid}, 72'd0);
    check("bp_release_acc",   out_acc,            72'd0);
    push(64'd20, 1'b1);
    @(negedge clk);
    check("bp_next_acc",   out_acc,            72'd20);
    check("bp_next_count", {64'd0, out_count}, 72'd1);
    @(negedge clk);

    // acc_clear mid-group drops in-flight beat and refuses the coincident one
    push(64'd3, 1'b0);
    push(64'd4, 1'b0);
    acc_clear = 1'b1; in_valid = 1'b1; in_prod = 64'd50;
    #1;
    check("clr_in_ready", {71'd0, in_ready}, 72'd0);
    @(negedge clk);
    acc_clear = 1'b0; in_valid = 1'b0;
    check("clr_acc",   out_acc,            72'd0);
    check("clr_count", {64'd0, out_count}, 72'd0);
    push(64'd7, 1'b1);
    @(negedge clk);
    check("clr_valid", {71'd0, out_valid}, 72'd1);
    check("clr_res",   out_acc,            72'd7);
    check("clr_cnt1",  {64'd0, out_count}, 72'd1);
    @(negedge clk);

    // Asynchronous reset mid-group
    push(64'd11, 1'b0);
    push(64'd12, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_mid_acc",   out_acc,            72'd0);
    check("arst_mid_count", {64'd0, out_count}, 72'd0);
    check("arst_mid_ready", {71'd0, in_ready},  72'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset while in HOLD
    out_ready = 1'b0;
    push(64'd1, 1'b1);
    @(negedge clk);
    check("arst_hold_pre", {71'd0, out_valid}, 72'd1);
    rst_n = 1'b0;
    #1;
    check("arst_hold_valid", {71'd0, out_valid}, 72'd0);
    check("arst_hold_acc",   out_acc,            72'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    push(64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    push(64'd5, 1'b1);
    @(negedge clk);
    check("post_arst_acc",   out_acc,               72'd3);
    check("post_arst_count", {64'd0, out_count},    72'd2);
    check("post_arst_ovf",   {71'd0, out_overflow}, 72'd0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
